// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch redirect flush and
// multi-cycle MDU hold, with saturating stall/redirect performance counters.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_branch_taken,
    input  logic                  ex_mdu_req,
    input  logic                  mdu_done,
    output logic                  pc_write_en,
    output logic                  if_id_write_en,
    output logic                  if_id_flush,
    output logic                  id_ex_write_en,
    output logic                  id_ex_flush,
    output logic                  ex_mem_bubble,
    output logic                  mdu_busy,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    typedef enum logic {RUN, MDU_WAIT} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] stall_reg, flush_reg;
    logic             load_use, redirect, hold;

    always_comb begin
        load_use = id_valid && ex_valid && ex_mem_read && (ex_rd_addr != '0) &&
                   ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                    (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));
        redirect = (state_reg == RUN) && ex_valid && ex_branch_taken;
        hold     = ((state_reg == RUN) && ex_valid && ex_mdu_req) ||
                   ((state_reg == MDU_WAIT) && !mdu_done);
    end

    always_comb begin
        state_next     = state_reg;
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_write_en = 1'b1;
        id_ex_flush    = 1'b0;
        ex_mem_bubble  = 1'b0;
        mdu_busy       = (state_reg == MDU_WAIT);

        case (state_reg)
            RUN: begin
                // A redirect kills the MDU op in EX, so it never enters the wait.
                if (redirect) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (hold) begin
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    id_ex_write_en = 1'b0;
                    ex_mem_bubble  = 1'b1;
                    state_next     = MDU_WAIT;
                end else if (load_use) begin
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    id_ex_flush    = 1'b1;
                end
            end
            MDU_WAIT: begin
                if (hold) begin
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    id_ex_write_en = 1'b0;
                    ex_mem_bubble  = 1'b1;
                end else begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
            stall_reg <= '0;
            flush_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (!pc_write_en && (stall_reg != '1))
                stall_reg <= stall_reg + CNT_W'(1);
            if (redirect && (flush_reg != '1))
                flush_reg <= flush_reg + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_reg;
    assign flush_count  = flush_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised and directed bench for pipe_hazard_ctrl against a behavioural
// model of the hazard rules; counters run at 4 bits to reach saturation.
module tb_pipe_hazard_ctrl;

    localparam int AW    = 5;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_uses_rs1, id_uses_rs2;
    logic [AW-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic          ex_valid, ex_mem_read, ex_branch_taken, ex_mdu_req, mdu_done;
    logic          pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en;
    logic          id_ex_flush, ex_mem_bubble, mdu_busy;
    logic [CW-1:0] stall_cycles, flush_count;

    int n_checks = 0;
    int n_fails  = 0;

    // model state: whether an MDU op is being waited on, and the two counts
    bit m_waiting;
    int m_stall, m_flush;
    int hold_seen, busy_seen;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
        .ex_branch_taken(ex_branch_taken), .ex_mdu_req(ex_mdu_req), .mdu_done(mdu_done),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .if_id_flush(if_id_flush),
        .id_ex_write_en(id_ex_write_en), .id_ex_flush(id_ex_flush),
        .ex_mem_bubble(ex_mem_bubble), .mdu_busy(mdu_busy),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; id_valid = 1'b0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        ex_mdu_req = 1'b0; mdu_done = 1'b0;
    endtask

    // One cycle: inputs already driven just after a rising edge.
    // Outputs order: {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, bubble, busy}
    task automatic step(input string tag);
        bit         lu, redir, stalled;
        logic [6:0] exp, got;
        lu = id_valid && ex_valid && ex_mem_read && (ex_rd_addr != 0) &&
             ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) ||
              (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
        redir   = !m_waiting && ex_valid && ex_branch_taken;
        stalled = m_waiting ? !mdu_done : (ex_valid && ex_mdu_req);
        if (redir)                 exp = 7'b1111100;
        else if (stalled)          exp = 7'b0000010;
        else if (!m_waiting && lu) exp = 7'b0001100;
        else                       exp = 7'b1101000;
        exp[0] = m_waiting;

        #4;
        got = {pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en,
               id_ex_flush, ex_mem_bubble, mdu_busy};
        check_eq({tag, ".ctrl"}, 32'(got), 32'(exp));
        check_eq({tag, ".stall"}, 32'(stall_cycles), 32'(m_stall));
        check_eq({tag, ".flush"}, 32'(flush_count), 32'(m_flush));
        if (!got[6]) hold_seen++;
        if (got[0])  busy_seen++;

        if (rst) begin
            m_waiting = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            if (!exp[6] && m_stall < CMAX) m_stall++;
            if (redir && m_flush < CMAX)   m_flush++;
            m_waiting = m_waiting ? !mdu_done : (ex_valid && ex_mdu_req && !ex_branch_taken);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step("rst");
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        m_waiting = 1'b0; m_stall = 0; m_flush = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // idle after reset: all enables on, nothing flushed, counters clear
        step("reset_idle");
        check_eq("reset_counters", 32'(stall_cycles), 32'd0);

        // load-use on rs1 = rd = 5: exactly one stall cycle
        do_reset();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd_addr = 5;
        id_valid = 1'b1; id_uses_rs1 = 1'b1; id_rs1_addr = 5;
        step("load_use");
        idle_inputs(); id_valid = 1'b1;
        step("load_use_next");
        check_eq("load_use_stall_cnt", 32'(stall_cycles), 32'd1);

        // load to x0 never stalls
        do_reset();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd_addr = 0;
        id_valid = 1'b1; id_uses_rs1 = 1'b1; id_rs1_addr = 0;
        step("load_x0");
        idle_inputs();
        step("load_x0_next");
        check_eq("load_x0_stall_cnt", 32'(stall_cycles), 32'd0);

        // redirect beats a simultaneous load-use on rs2
        do_reset();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd_addr = 7; ex_branch_taken = 1'b1;
        id_valid = 1'b1; id_uses_rs2 = 1'b1; id_rs2_addr = 7;
        step("redirect_lu");
        idle_inputs();
        step("redirect_next");
        check_eq("redirect_flush_cnt", 32'(flush_count), 32'd1);
        check_eq("redirect_stall_cnt", 32'(stall_cycles), 32'd0);

        // MDU request then done after several wait cycles
        do_reset();
        hold_seen = 0; busy_seen = 0;
        ex_valid = 1'b1; ex_mdu_req = 1'b1;
        step("mdu_req");
        for (int i = 0; i < 3; i++) step("mdu_wait");
        mdu_done = 1'b1;
        step("mdu_done");
        idle_inputs();
        step("mdu_after");
        check_eq("mdu_hold_cycles", 32'(hold_seen), 32'd4);
        check_eq("mdu_busy_cycles", 32'(busy_seen), 32'd4);
        check_eq("mdu_stall_cnt", 32'(stall_cycles), 32'd4);

        // reset during the wait, then a late done must be ignored
        do_reset();
        ex_valid = 1'b1; ex_mdu_req = 1'b1;
        step("rw_req");
        idle_inputs();
        step("rw_wait");
        rst = 1'b1;
        step("rw_rst");
        rst = 1'b0; mdu_done = 1'b1;
        step("rw_late_done");
        check_eq("rw_busy", 32'(mdu_busy), 32'd0);
        check_eq("rw_pc_we", 32'(pc_write_en), 32'd1);
        check_eq("rw_stall_cnt", 32'(stall_cycles), 32'd0);

        // long MDU stall saturates the 4-bit stall counter
        do_reset();
        ex_valid = 1'b1; ex_mdu_req = 1'b1;
        step("sat_req");
        idle_inputs();
        for (int i = 0; i < 19; i++) step("sat_wait");
        step("sat_end");
        check_eq("sat_stall_cnt", 32'(stall_cycles), 32'(CMAX));

        // randomised traffic over a small register set to provoke matches
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst             = ($urandom_range(0, 79) == 0);
            id_valid        = $urandom_range(0, 3) != 0;
            id_uses_rs1     = $urandom_range(0, 1);
            id_uses_rs2     = $urandom_range(0, 1);
            id_rs1_addr     = AW'($urandom_range(0, 3));
            id_rs2_addr     = AW'($urandom_range(0, 3));
            ex_rd_addr      = AW'($urandom_range(0, 3));
            ex_valid        = $urandom_range(0, 3) != 0;
            ex_mem_read     = $urandom_range(0, 2) == 0;
            ex_branch_taken = $urandom_range(0, 5) == 0;
            ex_mdu_req      = $urandom_range(0, 7) == 0;
            mdu_done        = $urandom_range(0, 3) == 0;
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
